// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: two-stage pipelined WIDTH-bit carry-lookahead adder/subtractor with valid/ready.
// Optional V/Z flag outputs are built only when CLA_FLAGS_EN is defined. Revision: 1.0
`default_nettype none

module cla_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             PG,
  output logic             GG,
  output logic             V,
  output logic             Z
);

  localparam int NG = WIDTH / GROUP;

  generate
    if ((WIDTH % GROUP) != 0 || WIDTH < GROUP || GROUP < 2 || GROUP > 8) begin : g_param_check
      $fatal(1, "cla_adder_pipe: WIDTH must be a multiple of GROUP, GROUP in 2..8");
    end
  endgenerate

  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic             s2_adv, accept, s2_load;
  logic [WIDTH-1:0] p_d, g_d, p_q, g_q;
  logic             c0_d, c0_q;
  logic [NG-1:0]    gp_d, gg_d, gp_q, gg_q;
  logic [NG:0]      c_grp;
  logic [WIDTH-1:0] c_bit;
  logic             word_gg;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_q, pg_q, ggw_q;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_adv;

  assign s1_valid_d  = accept ? 1'b1 : (s2_adv ? 1'b0 : s1_valid_q);
  assign out_valid_d = s2_adv ? s1_valid_q : out_valid_q;

  // Stage 1: effective operand, bit p/g and group P/G with carry-in 0
  always_comb begin
    logic [WIDTH-1:0] be;
    logic             term;
    be   = sub ? ~B : B;
    c0_d = sub ? 1'b1 : Cin;
    p_d  = A ^ be;
    g_d  = A & be;
    gp_d = '0;
    gg_d = '0;
    for (int k = 0; k < NG; k++) begin
      gp_d[k] = &p_d[k*GROUP +: GROUP];
      for (int j = 0; j < GROUP; j++) begin
        term = g_d[k*GROUP + j];
        for (int m = j + 1; m < GROUP; m++) term = term & p_d[k*GROUP + m];
        gg_d[k] = gg_d[k] | term;
      end
    end
  end

  // Stage 2: flat second-level lookahead, then in-group lookahead from each C(k)
  always_comb begin
    logic term;
    c_grp    = '0;
    c_grp[0] = c0_q;
    word_gg  = 1'b0;
    for (int k = 0; k < NG; k++) begin
      term = c0_q;
      for (int i = 0; i <= k; i++) term = term & gp_q[i];
      c_grp[k+1] = term;
      for (int j = 0; j <= k; j++) begin
        term = gg_q[j];
        for (int i = j + 1; i <= k; i++) term = term & gp_q[i];
        c_grp[k+1] = c_grp[k+1] | term;
        if (k == NG - 1) word_gg = word_gg | term;
      end
    end
    c_bit = '0;
    for (int k = 0; k < NG; k++) begin
      for (int m = 0; m < GROUP; m++) begin
        term = c_grp[k];
        for (int i = 0; i < m; i++) term = term & p_q[k*GROUP + i];
        c_bit[k*GROUP + m] = term;
        for (int j = 0; j < m; j++) begin
          term = g_q[k*GROUP + j];
          for (int i = j + 1; i < m; i++) term = term & p_q[k*GROUP + i];
          c_bit[k*GROUP + m] = c_bit[k*GROUP + m] | term;
        end
      end
    end
    s_d = p_q ^ c_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      c0_q       <= 1'b0;
      gp_q       <= '0;
      gg_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        p_q  <= p_d;
        g_q  <= g_d;
        c0_q <= c0_d;
        gp_q <= gp_d;
        gg_q <= gg_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      pg_q        <= 1'b0;
      ggw_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_load) begin
        s_q    <= s_d;
        cout_q <= c_grp[NG];
        pg_q   <= &gp_q;
        ggw_q  <= word_gg;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign PG        = pg_q;
  assign GG        = ggw_q;

`ifdef CLA_FLAGS_EN
  logic v_q, z_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else if (s2_load) begin
      v_q <= c_bit[WIDTH-1] ^ c_grp[NG];
      z_q <= (s_d == '0);
    end
  end
  assign V = v_q;
  assign Z = z_q;
`else
  assign V = 1'b0;
  assign Z = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor.
- Next generation of the team's 4-bit CLA: generalised to WIDTH bits built from GROUP-bit lookahead groups, with a second-level lookahead across groups and add/sub mode.
- Uses a valid/ready handshake so it can sit in the MIPS execute path or any streaming datapath.
- Exports word-level propagate/generate (PG/GG) for cascading into a higher-level lookahead unit.

Parameters:
- WIDTH, 16, operand/sum width; must be a multiple of GROUP and >= GROUP.
- GROUP, 4, bits per first-level lookahead group; legal range 2..8.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry-in; ignored when sub=1
- sub  input  1  0 = A+B+Cin; 1 = A-B (A + ~B + 1)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- S  output  WIDTH  sum/difference
- Cout  output  1  carry out of MSB; for sub, 1 = no borrow
- PG  output  1  word propagate: AND of all effective bit propagates
- GG  output  1  word generate, independent of carry-in
- V  output  1  signed overflow (optional feature)
- Z  output  1  S == 0 (optional feature)

Behaviour:
- Reset: async on rst_n low; all stage valids, S, Cout, PG, GG, V and Z clear to 0 immediately. Any in-flight operations are discarded; none emerge after release.
- Stage 1, on accept:
  - Register Be = sub ? ~B : B and c0 = sub ? 1 : Cin.
  - Register per-bit p = A^Be and g = A&Be.
  - Register per-group Pk = AND of p, and Gk from GROUP-bit lookahead.
- Stage 2:
  - Group carries: C(k+1) = Gk | Pk&C(k), expanded as flat lookahead, no ripple across groups.
  - In-group carries by lookahead from C(k).
  - S = p ^ carries; Cout = C(WIDTH/GROUP).
  - PG = AND of all Pk; GG = word-level generate.
  - All outputs are registered.
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput is 1 op/cycle.
- Handshake:
  - Accept when in_valid && in_ready.
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv (combinational from state and out_ready).
  - Stage 1 moves to stage 2 when s1_valid && s2_adv.
  - Stage 1 is refilled in the same cycle it drains (no bubble).
- Stall: while out_valid && !out_ready, S/Cout/PG/GG/V/Z hold stable, and stage 1 holds if occupied. At most 2 ops are in flight.
- Result drained and nothing new arriving: out_valid drops next cycle; data registers keep their last values.
- Ordering is strictly FIFO.
- Widths:
  - WIDTH wraps modulo 2^WIDTH.
  - Cout is the true carry.
  - PG=1 means carry-in propagates through the whole word.
  - GG=1 means a carry-out is generated regardless of carry-in.
- Illegal parameters (WIDTH%GROUP != 0) are caught by an elaboration-time check that stops simulation.

Optional Feature:
- Macro: CLA_FLAGS_EN.
- Defined:
  - V = carry into MSB XOR Cout.
  - Z = (S == 0).
  - Both are registered with S and updated only on stage-2 load.
- Undefined: V and Z are tied to 0, with no flag logic generated. The port list is unchanged.

Test Plan (defaults WIDTH=16, GROUP=4, out_ready=1 unless stated):
- Basic add: A=0x0001, B=0x0000, Cin=0, sub=0 → 2 cycles later S=0x0001, Cout=0, PG=0, GG=0, Z=0.
- Cross-group carry: A=0xFFFF, B=0x0001, Cin=0 → S=0x0000, Cout=1, PG=0, GG=1, Z=1 (flags build). Then A=0xFFFF, B=0x0000, Cin=1 → S=0x0000, Cout=1, PG=1, GG=0.
- Subtract:
  - A=0x0005, B=0x0007, sub=1, Cin=1 (ignored) → S=0xFFFE, Cout=0, V=0.
  - A=0x8000, B=0x0001, sub=1 → S=0x7FFF, Cout=1, V=1.
- Back-to-back: 4 consecutive accepts (1+1, 2+2, 3+3, 4+4) → S=0x0002, 0x0004, 0x0006, 0x0008 on 4 consecutive cycles, starting 2 cycles after the first accept, with in_ready held at 1.
- Backpressure: accept 3 ops, hold out_ready=0 for 4 cycles → in_ready=0 after 2 ops in flight; first result held stable. On release, results drain in order with no loss or duplication.
- Async reset mid-operation: both stages valid, pull rst_n low between clock edges → out_valid=0 and S=0 immediately. After release, no stale results appear and in_ready=1.
